// File: rtl/lpm_inpad_sync.sv
// lpm_inpad_sync: per-channel pad synchroniser, consecutive-sample glitch filter and edge strobes.
// Optional sticky change flags (change_clr/change ports) when LPM_INPAD_SYNC_STICKY_EN is defined.

module lpm_inpad_sync_lane #(
    parameter int STAGES  = 2,
    parameter int FILT    = 4,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic aclr_n,
    input  logic clken,
    input  logic pad,
`ifdef LPM_INPAD_SYNC_STICKY_EN
    input  logic change_clr,
    output logic change,
`endif
    output logic result,
    output logic rise,
    output logic fall
);

    localparam int            CW       = $clog2(FILT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT - 1);

    logic [STAGES-1:0] s;
    logic [CW-1:0]     cnt;
    logic              sync;
    logic              differ;
    logic              fire;

    assign sync   = s[STAGES-1];
    assign differ = sync ^ result;
    // Counter tops out at FILT-1 and is cleared on fire, so it never wraps.
    assign fire   = differ && (cnt == CNT_LAST);

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n)
            s <= {STAGES{RST_VAL}};
        else if (clken)
            s <= {s[STAGES-2:0], pad};
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            cnt    <= '0;
            result <= RST_VAL;
        end else if (clken) begin
            if (!differ || fire)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (fire)
                result <= sync;
        end
    end

    // Strobes drop on a disabled edge so they stay one enabled cycle wide.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else if (!clken) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= fire & sync;
            fall <= fire & ~sync;
        end
    end

`ifdef LPM_INPAD_SYNC_STICKY_EN
    // A new event beats a clear landing on the same edge.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n)
            change <= 1'b0;
        else if (clken) begin
            if (fire)
                change <= 1'b1;
            else if (change_clr)
                change <= 1'b0;
        end
    end
`endif

endmodule

module lpm_inpad_sync #(
    parameter int             lpm_width         = 1,
    parameter int             lpm_sync_stages   = 2,
    parameter int             lpm_filter_cycles = 4,
    parameter [lpm_width-1:0] lpm_reset_value   = '0,
    parameter                 lpm_type          = "lpm_inpad_sync",
    parameter                 lpm_hint          = "UNUSED"
) (
    input  logic                 clock,
    input  logic                 aclr_n,
    input  logic                 clken,
    input  logic [lpm_width-1:0] pad,
`ifdef LPM_INPAD_SYNC_STICKY_EN
    input  logic [lpm_width-1:0] change_clr,
    output logic [lpm_width-1:0] change,
`endif
    output logic [lpm_width-1:0] result,
    output logic [lpm_width-1:0] rise,
    output logic [lpm_width-1:0] fall
);

    if (lpm_width < 1) begin : g_bad_width
        $fatal(1, "lpm_inpad_sync: lpm_width must be >= 1");
    end
    if (lpm_sync_stages < 2) begin : g_bad_stages
        $fatal(1, "lpm_inpad_sync: lpm_sync_stages must be >= 2");
    end
    if (lpm_filter_cycles < 1) begin : g_bad_filter
        $fatal(1, "lpm_inpad_sync: lpm_filter_cycles must be >= 1");
    end
    if (lpm_type != "lpm_inpad_sync" && lpm_hint != "") begin : g_bad_type
        $warning("lpm_inpad_sync: unexpected lpm_type");
    end

    for (genvar i = 0; i < lpm_width; i++) begin : g_lane
        lpm_inpad_sync_lane #(
            .STAGES  (lpm_sync_stages),
            .FILT    (lpm_filter_cycles),
            .RST_VAL (lpm_reset_value[i])
        ) u_lane (
            .clock      (clock),
            .aclr_n     (aclr_n),
            .clken      (clken),
            .pad        (pad[i]),
`ifdef LPM_INPAD_SYNC_STICKY_EN
            .change_clr (change_clr[i]),
            .change     (change[i]),
`endif
            .result     (result[i]),
            .rise       (rise[i]),
            .fall       (fall[i])
        );
    end

endmodule

// File: tb/tb_lpm_inpad_sync.sv
// Bench for lpm_inpad_sync: two instances (reset 0000 and 1010) against a sample-history model.
module tb_lpm_inpad_sync;

    localparam int         W   = 4;
    localparam int         STG = 2;
    localparam int         FLT = 3;
    localparam logic [3:0] RV0 = 4'b0000;
    localparam logic [3:0] RV1 = 4'b1010;

    logic       clock  = 1'b0;
    logic       aclr_n = 1'b0;
    logic       clken  = 1'b1;
    logic [3:0] pad    = 4'b0000;
    logic [3:0] change_clr = 4'b0000;
    logic [3:0] res0, rise0, fall0, res1, rise1, fall1;
    logic [3:0] chg0, chg1;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clock = ~clock;

    lpm_inpad_sync #(.lpm_width(W), .lpm_sync_stages(STG), .lpm_filter_cycles(FLT),
                     .lpm_reset_value(RV0)) dut0 (
        .clock(clock), .aclr_n(aclr_n), .clken(clken), .pad(pad),
`ifdef LPM_INPAD_SYNC_STICKY_EN
        .change_clr(change_clr), .change(chg0),
`endif
        .result(res0), .rise(rise0), .fall(fall0));

    lpm_inpad_sync #(.lpm_width(W), .lpm_sync_stages(STG), .lpm_filter_cycles(FLT),
                     .lpm_reset_value(RV1)) dut1 (
        .clock(clock), .aclr_n(aclr_n), .clken(clken), .pad(pad),
`ifdef LPM_INPAD_SYNC_STICKY_EN
        .change_clr(change_clr), .change(chg1),
`endif
        .result(res1), .rise(rise1), .fall(fall1));

`ifndef LPM_INPAD_SYNC_STICKY_EN
    assign chg0 = 4'b0000;
    assign chg1 = 4'b0000;
`endif

    // Model: sync on enabled edge j is the pad sampled on enabled edge j-STG;
    // result follows sync once it has differed for FLT consecutive enabled edges.
    logic [3:0] samp [2][4096];
    int         m_n [2];
    int         m_run [2][4];
    logic [3:0] m_res [2], m_rise [2], m_fall [2], m_chg [2];
    logic [3:0] m_sync;

    always @(posedge clock or negedge aclr_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!aclr_n) begin
                m_n[d]    = 0;
                m_res[d]  = (d == 1) ? RV1 : RV0;
                m_rise[d] = '0;
                m_fall[d] = '0;
                m_chg[d]  = '0;
                for (int b = 0; b < 4; b++) m_run[d][b] = 0;
            end else if (!clken) begin
                m_rise[d] = '0;
                m_fall[d] = '0;
            end else begin
                m_sync = (m_n[d] >= STG) ? samp[d][m_n[d]-STG] : ((d == 1) ? RV1 : RV0);
                samp[d][m_n[d]] = pad;
                m_n[d]++;
                m_rise[d] = '0;
                m_fall[d] = '0;
                for (int b = 0; b < 4; b++) begin
                    if (m_sync[b] != m_res[d][b]) begin
                        m_run[d][b]++;
                        if (m_run[d][b] == FLT) begin
                            m_res[d][b]  = m_sync[b];
                            m_rise[d][b] = m_sync[b];
                            m_fall[d][b] = ~m_sync[b];
                            m_run[d][b]  = 0;
                        end
                    end else begin
                        m_run[d][b] = 0;
                    end
                end
                m_chg[d] = m_rise[d] | m_fall[d] | (m_chg[d] & ~change_clr);
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (cmp_en && aclr_n) begin
            chk("m_res0", res0, m_res[0]);   chk("m_rise0", rise0, m_rise[0]);
            chk("m_fall0", fall0, m_fall[0]); chk("m_res1", res1, m_res[1]);
            chk("m_rise1", rise1, m_rise[1]); chk("m_fall1", fall1, m_fall[1]);
`ifdef LPM_INPAD_SYNC_STICKY_EN
            chk("m_chg0", chg0, m_chg[0]);   chk("m_chg1", chg1, m_chg[1]);
`endif
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        aclr_n = 1'b0;
        clken  = 1'b1;
        pad    = 4'b0000;
        tick();
        tick();
        chk("rst_res0", res0, 4'b0000);
        chk("rst_res1", res1, 4'b1010);
        chk("rst_rise", rise0 | rise1, 4'b0000);
        chk("rst_fall", fall0 | fall1, 4'b0000);
        aclr_n = 1'b1;
        cmp_en = 1'b1;

        // Clean step on bit 0
        pad = 4'b0001;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e < 5) begin
                chk("t1_res_pre", res0, 4'b0000);
                chk("t1_rise_pre", rise0, 4'b0000);
            end else if (e == 5) begin
                chk("t1_res", res0, 4'b0001);
                chk("t1_rise", rise0, 4'b0001);
                chk("t1_res1", res1, 4'b0001);
                chk("t1_rise1", rise1, 4'b0001);
                chk("t1_fall1", fall1, 4'b1010);
            end else begin
                chk("t1_rise_post", rise0, 4'b0000);
            end
        end

        // Two-sample glitch on bit 1 is swallowed
        pad = 4'b0011;
        tick();
        tick();
        pad = 4'b0001;
        repeat (6) tick();
        chk("t2_res", res0, 4'b0001);

        // All channels fall together
        pad = 4'b1111;
        repeat (6) tick();
        chk("t3_res_hi", res0, 4'b1111);
        pad = 4'b0000;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e < 5) chk("t3_res_pre", res0, 4'b1111);
            else if (e == 5) begin
                chk("t3_res", res0, 4'b0000);
                chk("t3_fall", fall0, 4'b1111);
                chk("t3_rise", rise0, 4'b0000);
            end else chk("t3_fall_post", fall0, 4'b0000);
        end

        // clken low for 3 edges mid-count delays the update by 3
        pad = 4'b1111;
        repeat (3) tick();
        clken = 1'b0;
        repeat (3) begin
            tick();
            chk("t4_res_frozen", res0, 4'b0000);
            chk("t4_rise_frozen", rise0, 4'b0000);
        end
        clken = 1'b1;
        tick();
        chk("t4_res_e7", res0, 4'b0000);
        tick();
        chk("t4_res_e8", res0, 4'b1111);
        chk("t4_rise_e8", rise0, 4'b1111);

        // Async reset between edges while a count is pending
        pad = 4'b0101;
        repeat (3) tick();
        #2;
        aclr_n = 1'b0;
        #1;
        chk("t5_res1_async", res1, 4'b1010);
        chk("t5_res0_async", res0, 4'b0000);
        chk("t5_strobe_async", rise1 | fall1, 4'b0000);
        tick();
        aclr_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            if (e < 5) chk("t5_res1_pre", res1, 4'b1010);
            else begin
                chk("t5_res1", res1, 4'b0101);
                chk("t5_rise1", rise1, 4'b0101);
                chk("t5_fall1", fall1, 4'b1010);
                chk("t5_res0", res0, 4'b0101);
            end
        end

`ifdef LPM_INPAD_SYNC_STICKY_EN
        chk("t6_chg_set", chg0, 4'b0101);
        change_clr = 4'b1111;
        tick();
        chk("t6_chg_clr", chg0, 4'b0000);
        change_clr = 4'b0000;
        pad = 4'b0001;
        repeat (4) tick();
        change_clr = 4'b0100;
        tick();
        chk("t6_fall", fall0, 4'b0100);
        chk("t6_set_wins", chg0, 4'b0100);
        tick();
        chk("t6_clr_noevt", chg0, 4'b0000);
        change_clr = 4'b0000;
`endif

        repeat (3) tick();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
